// File: rtl/mvm_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvm_driver: stages upstream operand words, sequences an MVM core through
// matrix/vector load and start, and buffers its K results.        Rev 1.0
// ---------------------------------------------------------------------------
module mvm_driver #(
  parameter int K = 12,
  parameter int B = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_data,
  input  logic           in_new_matrix,
  output logic           loadMatrix,
  output logic           loadVector,
  output logic           start,
  output logic [B-1:0]   mvm_data,
  input  logic           mvm_done,
  input  logic [2*B-1:0] mvm_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*B-1:0] out_data,
  output logic           busy
);

  localparam int MAT_N = K * K;
  localparam int TOT_N = MAT_N + K;
  localparam int AW    = (TOT_N > 1) ? $clog2(TOT_N) : 1;
  localparam int IW    = AW + 1;
  localparam int PW    = (K > 1) ? $clog2(K) : 1;
  localparam int CW    = $clog2(K + 1);

  localparam logic [AW-1:0] VEC_BASE  = AW'(MAT_N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(TOT_N - 1);
  localparam logic [IW-1:0] MAT_END   = IW'(MAT_N);
  localparam logic [IW-1:0] MAT_GAP   = IW'(MAT_N + 1);
  localparam logic [IW-1:0] VEC_END   = IW'(K);
  localparam logic [IW-1:0] VEC_GAP   = IW'(K + 1);
  localparam logic [IW-1:0] RES_LAST  = IW'(K - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(K - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_LDM     = 3'd2,
    S_LDV     = 3'd3,
    S_RUN     = 3'd4,
    S_WAIT    = 3'd5,
    S_COLLECT = 3'd6,
    S_DRAIN   = 3'd7
  } state_t;

  state_t         state_q;
  logic           in_ready_q;
  logic           load_m_q;
  logic           load_v_q;
  logic           start_q;
  logic           job_flag_q;
  logic           mat_loaded_q;
  logic [B-1:0]   mvm_data_q;
  logic [AW-1:0]  wr_addr_q;
  logic [IW-1:0]  idx_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [B-1:0]   stage_q [TOT_N];
  logic [2*B-1:0] fifo_q  [K];

  logic           accept;
  logic           flag_d;
  logic           last_word;
  logic           take_matrix;
  logic           push;
  logic           pop;
  logic           fifo_empty;
  logic [AW-1:0]  wr_addr_d;

  // A vector-only request before any matrix has been loaded is promoted to a full job.
  assign accept      = in_valid && in_ready_q;
  assign flag_d      = in_new_matrix || !mat_loaded_q;
  assign wr_addr_d   = (state_q == S_IDLE) ? (flag_d ? '0 : VEC_BASE) : wr_addr_q;
  assign last_word   = (wr_addr_d == LAST_ADDR);
  assign take_matrix = (state_q == S_IDLE) ? flag_d : job_flag_q;

  assign fifo_empty  = (count_q == '0);
  assign push        = (state_q == S_COLLECT);
  assign out_valid   = ((state_q == S_COLLECT) || (state_q == S_DRAIN)) && !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign out_data    = out_valid ? fifo_q[rd_ptr_q] : '0;

  assign in_ready    = in_ready_q;
  assign loadMatrix  = load_m_q;
  assign loadVector  = load_v_q;
  assign start       = start_q;
  assign mvm_data    = mvm_data_q;
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (accept) begin
      stage_q[wr_addr_d] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mvm_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      load_m_q     <= 1'b0;
      load_v_q     <= 1'b0;
      start_q      <= 1'b0;
      job_flag_q   <= 1'b0;
      mat_loaded_q <= 1'b0;
      mvm_data_q   <= '0;
      wr_addr_q    <= '0;
      idx_q        <= '0;
    end else begin
      load_m_q <= 1'b0;
      load_v_q <= 1'b0;
      start_q  <= 1'b0;
      unique case (state_q)
        S_IDLE, S_FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            wr_addr_q <= wr_addr_d + AW'(1);
            if (state_q == S_IDLE) begin
              job_flag_q <= flag_d;
            end
            if (last_word) begin
              in_ready_q <= 1'b0;
              idx_q      <= '0;
              if (take_matrix) begin
                state_q      <= S_LDM;
                load_m_q     <= 1'b1;
                mat_loaded_q <= 1'b1;
              end else begin
                state_q  <= S_LDV;
                load_v_q <= 1'b1;
              end
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        // Words follow the load pulse back to back; one idle slot precedes the next pulse.
        S_LDM: begin
          idx_q <= idx_q + IW'(1);
          if (idx_q < MAT_END) begin
            mvm_data_q <= stage_q[idx_q[AW-1:0]];
          end else begin
            mvm_data_q <= '0;
          end
          if (idx_q == MAT_GAP) begin
            state_q  <= S_LDV;
            load_v_q <= 1'b1;
            idx_q    <= '0;
          end
        end
        S_LDV: begin
          idx_q <= idx_q + IW'(1);
          if (idx_q < VEC_END) begin
            mvm_data_q <= stage_q[VEC_BASE + idx_q[AW-1:0]];
          end else begin
            mvm_data_q <= '0;
          end
          if (idx_q == VEC_GAP) begin
            state_q <= S_RUN;
            start_q <= 1'b1;
            idx_q   <= '0;
          end
        end
        S_RUN: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mvm_done) begin
            state_q <= S_COLLECT;
            idx_q   <= '0;
          end
        end
        S_COLLECT: begin
          idx_q <= idx_q + IW'(1);
          if (idx_q == RES_LAST) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty || ((count_q == CNT_ONE) && pop)) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvm_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mvm_driver: directed job table plus abort/spurious-done sequences,
// with a small behavioural MVM core answering the driver.         Rev 1.0
// ---------------------------------------------------------------------------
module tb_mvm_driver;
  localparam int K  = 2;
  localparam int B  = 8;
  localparam int TR = 4096;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_new_matrix, out_ready;
  logic [7:0]  in_data;
  logic        sp_done;
  logic [15:0] sp_res;
  logic        cm_done = 1'b0;
  logic [15:0] cm_res  = '0;

  logic        in_ready, loadMatrix, loadVector, start, out_valid, busy;
  logic [7:0]  mvm_data;
  logic [15:0] out_data;

  int n_cmp, n_bad;
  int cyc = 0;

  always #5 clk = ~clk;

  mvm_driver #(.K(K), .B(B)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_new_matrix(in_new_matrix),
    .loadMatrix   (loadMatrix),
    .loadVector   (loadVector),
    .start        (start),
    .mvm_data     (mvm_data),
    .mvm_done     (cm_done | sp_done),
    .mvm_result   (cm_res | sp_res),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  // Per-cycle trace of the core-facing outputs.
  logic [7:0] tr_data [TR];
  bit         tr_lm [TR];
  bit         tr_lv [TR];
  bit         tr_st [TR];

  always @(negedge clk) begin
    if (cyc < TR) begin
      tr_data[cyc] = mvm_data;
      tr_lm[cyc]   = loadMatrix;
      tr_lv[cyc]   = loadVector;
      tr_st[cyc]   = start;
    end
    cyc++;
  end

  // Behavioural MVM core: captures words after each load pulse, answers start
  // with done three cycles later and then K result words.
  int                 cm_ph = 0;
  int                 cm_i  = 0;
  int                 cm_k  = 0;
  logic signed [7:0]  cA [4];
  logic signed [7:0]  cx [2];
  logic signed [15:0] cy [2];

  always @(negedge clk) begin
    cm_done = 1'b0;
    cm_res  = '0;
    if (reset) begin
      cm_ph = 0;
    end else begin
      if (cm_ph == 1) begin
        cA[cm_i] = mvm_data; cm_i++;
        if (cm_i == 4) cm_ph = 0;
      end else if (cm_ph == 2) begin
        cx[cm_i] = mvm_data; cm_i++;
        if (cm_i == 2) cm_ph = 0;
      end else if (cm_ph == 3) begin
        cm_i--;
        if (cm_i == 0) begin cm_done = 1'b1; cm_ph = 4; end
      end else if (cm_ph == 4) begin
        cm_res = cy[cm_k]; cm_k++;
        if (cm_k == 2) cm_ph = 0;
      end
      if (loadMatrix) begin cm_ph = 1; cm_i = 0; end
      if (loadVector) begin cm_ph = 2; cm_i = 0; end
      if (start) begin
        cy[0] = cA[0] * cx[0] + cA[1] * cx[1];
        cy[1] = cA[2] * cx[0] + cA[3] * cx[1];
        cm_ph = 3; cm_i = 3; cm_k = 0;
      end
    end
  end

  typedef struct packed {
    logic            flag;
    logic            full;
    logic            gaps;
    logic [7:0]      hold;
    logic            exp_lm;
    logic [3:0][7:0] mat;
    logic [1:0][7:0] vec;
    logic [1:0][15:0] y;
  } job_t;

  job_t jobs [8];

  task automatic set_job(input int i, input bit f, input bit fu, input bit g, input int h,
                         input bit lm, input int m0, input int m1, input int m2, input int m3,
                         input int v0, input int v1, input int y0, input int y1);
    jobs[i].flag   = f;
    jobs[i].full   = fu;
    jobs[i].gaps   = g;
    jobs[i].hold   = 8'(h);
    jobs[i].exp_lm = lm;
    jobs[i].mat[0] = 8'(m0);
    jobs[i].mat[1] = 8'(m1);
    jobs[i].mat[2] = 8'(m2);
    jobs[i].mat[3] = 8'(m3);
    jobs[i].vec[0] = 8'(v0);
    jobs[i].vec[1] = 8'(v1);
    jobs[i].y[0]   = 16'(y0);
    jobs[i].y[1]   = 16'(y1);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic string jn(input int i, input string s);
    return $sformatf("job%0d_%s", i, s);
  endfunction

  task automatic send_words(input int i);
    int n, b;
    logic [7:0] w;
    n = (jobs[i].flag || jobs[i].full) ? 6 : 2;
    in_new_matrix = jobs[i].flag;
    for (int k = 0; k < n; k++) begin
      if (n == 6 && k < 4) w = jobs[i].mat[k];
      else if (n == 6)     w = jobs[i].vec[k - 4];
      else                 w = jobs[i].vec[k];
      b = 0;
      while (!in_ready && b < 50) begin @(negedge clk); b++; end
      chk(jn(i, $sformatf("ready_w%0d", k)), int'(in_ready), 1);
      in_valid = 1'b1; in_data = w;
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
      if (k == n - 1) chk(jn(i, "in_ready_drop"), int'(in_ready), 0);
      else if (jobs[i].gaps) repeat (2) @(negedge clk);
    end
    in_new_matrix = 1'b0;
  endtask

  task automatic run_job(input int i);
    int b, ng, bad, base, nlm, nlv, nst, l, v, s, werr, stray;
    int got [2];
    bit inwin;
    base = cyc;
    out_ready = (jobs[i].hold == 0);
    send_words(i);
    if (jobs[i].hold != 0) begin
      b = 0;
      while (!out_valid && b < 200) begin @(negedge clk); b++; end
      chk(jn(i, "hold_valid"), int'(out_valid), 1);
      bad = 0;
      repeat (jobs[i].hold) begin
        if (in_ready || !out_valid) bad++;
        @(negedge clk);
      end
      chk(jn(i, "hold_stalled"), bad, 0);
      chk(jn(i, "hold_head"), int'($signed(out_data)), int'($signed(jobs[i].y[0])));
      out_ready = 1'b1;
    end
    ng = 0; got[0] = 0; got[1] = 0; b = 0;
    while (ng < 2 && b < 300) begin
      if (out_valid && out_ready) begin got[ng] = int'($signed(out_data)); ng++; end
      @(negedge clk); b++;
    end
    chk(jn(i, "result_count"), ng, 2);
    chk(jn(i, "result0"), got[0], int'($signed(jobs[i].y[0])));
    chk(jn(i, "result1"), got[1], int'($signed(jobs[i].y[1])));
    b = 0;
    while (busy && b < 50) begin @(negedge clk); b++; end
    chk(jn(i, "idle_busy"), int'(busy), 0);
    chk(jn(i, "idle_ready"), int'(in_ready), 1);
    chk(jn(i, "idle_no_valid"), int'(out_valid), 0);

    nlm = 0; nlv = 0; nst = 0; l = -1; v = -1; s = -1;
    for (int c = base; c < cyc && c < TR; c++) begin
      if (tr_lm[c]) begin nlm++; if (l < 0) l = c; end
      if (tr_lv[c]) begin nlv++; if (v < 0) v = c; end
      if (tr_st[c]) begin nst++; if (s < 0) s = c; end
    end
    chk(jn(i, "lm_count"), nlm, int'(jobs[i].exp_lm));
    chk(jn(i, "lv_count"), nlv, 1);
    chk(jn(i, "st_count"), nst, 1);
    werr = 0;
    if (jobs[i].exp_lm && l >= 0) begin
      chk(jn(i, "lv_after_mat"), v - l, K * K + 2);
      for (int k = 0; k < 4; k++) if (tr_data[l + 1 + k] !== jobs[i].mat[k]) werr++;
    end
    if (v >= 0) for (int k = 0; k < 2; k++) if (tr_data[v + 1 + k] !== jobs[i].vec[k]) werr++;
    chk(jn(i, "burst_words"), werr, 0);
    chk(jn(i, "start_after_vec"), s - v, K + 2);
    stray = 0;
    for (int c = base; c < cyc && c < TR; c++) begin
      inwin = (jobs[i].exp_lm && l >= 0 && c > l && c <= l + 4) || (v >= 0 && c > v && c <= v + 2);
      if (!inwin && tr_data[c] != 8'd0) stray++;
    end
    chk(jn(i, "idle_data_zero"), stray, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, bad, base, np;
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_new_matrix = 1'b0;
    out_ready = 1'b1; sp_done = 1'b0; sp_res = '0;

    //       i  flag full gaps hold lm   A                 x          y
    set_job(0, 1, 1, 0, 0,  1,  1, 2, 3, 4,       5, 6,      17, 39);
    set_job(1, 0, 0, 0, 0,  0,  0, 0, 0, 0,       1, -1,     -1, -1);
    set_job(2, 1, 1, 1, 0,  1,  1, 2, 3, 4,       5, 6,      17, 39);
    set_job(3, 1, 1, 0, 20, 1,  1, 2, 3, 4,       5, 6,      17, 39);
    set_job(4, 0, 0, 0, 0,  0,  0, 0, 0, 0,       2, -3,     -4, -6);
    set_job(5, 1, 1, 0, 0,  1,  -1, 2, 0, -128,   3, -128,   -259, 16384);
    set_job(6, 0, 0, 0, 0,  0,  0, 0, 0, 0,       127, 1,    -125, -128);
    set_job(7, 0, 1, 0, 0,  1,  1, 2, 3, 4,       5, 6,      17, 39);

    #2 reset = 1'b1;
    #1 chk("reset_outputs", int'({in_ready, loadMatrix, loadVector, start, mvm_data,
                                   out_valid, out_data, busy}), 0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready_low", int'(in_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready), 1);
    chk("busy_after_reset", int'(busy), 0);

    sp_done = 1'b1; sp_res = 16'h1234;
    @(negedge clk);
    sp_done = 1'b0; sp_res = '0;
    bad = 0;
    repeat (10) begin
      if (out_valid || busy) bad++;
      @(negedge clk);
    end
    chk("spurious_done_ignored", bad, 0);

    for (int i = 0; i < 7; i++) run_job(i);

    // Abort after two matrix words have been presented.
    out_ready = 1'b1;
    send_words(0);
    b = 0;
    while (!loadMatrix && b < 20) begin @(negedge clk); b++; end
    chk("abort_saw_lm", int'(loadMatrix), 1);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_outputs", int'({in_ready, loadMatrix, loadVector, start, mvm_data,
                                  out_valid, out_data, busy}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = cyc;
    repeat (40) @(negedge clk);
    np = 0;
    for (int c = base; c < cyc && c < TR; c++) np += int'(tr_lm[c]) + int'(tr_lv[c]) + int'(tr_st[c]);
    chk("abort_no_pulses", np, 0);
    chk("abort_idle_ready", int'(in_ready), 1);
    chk("abort_no_valid", int'(out_valid), 0);

    run_job(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvm_driver.md
MVM_DRIVER -- requirements
Module: mvm_driver

Interface
REQ-001 Parameters: K (default 12): matrix dimension; B (default 8): operand width in bits.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  driver accepts upstream word.
- in_data  in  B  signed upstream operand word.
- in_new_matrix  in  1  sampled with the first word of a job; 1 = job carries K*K matrix words then K vector words; 0 = vector words only.
- loadMatrix  out  1  one-cycle pulse to the MVM core.
- loadVector  out  1  one-cycle pulse to the MVM core.
- start  out  1  one-cycle pulse to the MVM core.
- mvm_data  out  B  operand word to the MVM core data_in.
- mvm_done  in  1  MVM core done pulse.
- mvm_result  in  2B  MVM core data_out.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts result word.
- out_data  out  2B  signed result word.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 States: IDLE, FILL, LDM, LDV, RUN, WAIT, COLLECT, DRAIN.
REQ-004 IDLE: in_ready=1; the first accepted word latches in_new_matrix into a job flag, is stored, and moves the block to FILL.
REQ-005 in_new_matrix=0 on a job with no matrix loaded since reset SHALL be treated as 1.
REQ-006 FILL: in_ready=1; each accepted word is written to staging memory (K*K+K entries, B bits) at an incrementing address; there is no timeout on in_valid gaps.
REQ-007 FILL ends on the last word (K*K+K words total with the flag set, K words with it clear); in_ready drops the following cycle.
REQ-008 LDM (flag=1): loadMatrix high for cycle t; staged matrix words are driven row-major on mvm_data at t+1..t+K*K, one per cycle, with no gaps.
REQ-009 LDV: loadVector is asserted 2 cycles after the last matrix word (or at the first LDV cycle if LDM was skipped); K vector words follow on consecutive cycles.
REQ-010 RUN: start is asserted 2 cycles after the last vector word, for one cycle; then WAIT.
REQ-011 mvm_data SHALL be 0 whenever no word is being presented.
REQ-012 WAIT: on mvm_done at cycle d, mvm_result is captured into a K-entry result FIFO at d+1..d+K (COLLECT).
REQ-013 DRAIN: out_valid=!fifo_empty and out_data=FIFO head; a pop occurs when out_valid&&out_ready.
REQ-014 IDLE is re-entered when the FIFO empties, so at most one job is in flight.
REQ-015 Results are passed through unmodified at 2B bits, signed; the block performs no arithmetic.
REQ-016 COLLECT is never back-pressured: the FIFO is empty at start and holds exactly K entries.
REQ-017 mvm_done outside WAIT SHALL be ignored.
REQ-018 A pop during COLLECT is legal; FIFO pointers wrap modulo K.
REQ-019 in_valid is ignored outside IDLE and FILL.
REQ-020 The staging contents are retained after a job; a vector-only job overwrites only the vector region.

Reset
REQ-021 While reset=1, regardless of clock: state=IDLE; all counters and FIFO pointers 0; matrix-loaded flag 0; all outputs 0 except in_ready (0 during reset, 1 in the first cycle after release).
REQ-022 Reset asserted mid-job aborts the job with no further pulses; staging contents are don't-care.

Verification (K=2, B=8 bench; MVM model per REQ-008..012)
REQ-023 Full job: A=[1,2;3,4], x=[5,6], flag=1, in_valid continuous -> loadMatrix once, mvm_data 1,2,3,4 on consecutive cycles, loadVector 2 cycles later, 5,6, start 2 cycles later, out_data 17 then 39.
REQ-024 Vector-only job after REQ-023: x=[1,-1], flag=0 -> no loadMatrix pulse, results -1 and -1.
REQ-025 Upstream gaps: in_valid toggling 1,0,0,1 per word -> MVM burst still gap-free; results identical to REQ-023.
REQ-026 out_ready=0 for 20 cycles after done -> both results held in FIFO, in_ready=0 throughout, then 17,39 in order once out_ready=1.
REQ-027 Reset pulsed mid-LDM (after 2 matrix words) -> outputs 0 immediately; no loadVector or start pulse afterwards; a flag=0 job then behaves as flag=1.
REQ-028 Spurious mvm_done in IDLE -> no FIFO write; out_valid stays 0.
